// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and source encodings for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;
  localparam int DATA_W_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT = 5;
  localparam int NUM_REGS = 2 ** ADDR_W_DEFAULT;
  localparam int REG_ZERO = 0;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wbSrc_e;
endpackage

// File: rtl/regfile_wb_arbiter_hold_buf.sv
// One-entry writeback holding buffer: drops x0 writes, frees itself when granted.
module wb_hold_buf
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  output logic              ready,
  input  logic [ADDR_W-1:0] rdIn,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              grant,
  output logic              full,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] data,
  output logic              load
);
  // Ready depends only on held state and the grant, never on valid.
  assign ready = !full || grant;
  assign load  = valid && ready && (rdIn != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      rd   <= '0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      rd   <= rdIn;
      data <= dataIn;
    end else if (grant) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port
// in program order and publishes a per-register pending-write mask.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_W-1:0]    alu_rd,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [ADDR_W-1:0]    mem_rd,
  input  logic [DATA_W-1:0]    mem_data,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_rd,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [2**ADDR_W-1:0] busy_mask
);
  logic              aluFull, memFull, aluLoad, memLoad;
  logic              grantAlu, grantMem;
  logic              memOlder, memOlderNext;
  logic [ADDR_W-1:0] aluRd, memRd;
  logic [DATA_W-1:0] aluData, memData;
  wbSrc_e            grantSrc;

  wb_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) aluBuf (
    .clk(clk), .rst(rst), .valid(alu_valid), .ready(alu_ready),
    .rdIn(alu_rd), .dataIn(alu_data), .grant(grantAlu),
    .full(aluFull), .rd(aluRd), .data(aluData), .load(aluLoad)
  );

  wb_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) memBuf (
    .clk(clk), .rst(rst), .valid(mem_valid), .ready(mem_ready),
    .rdIn(mem_rd), .dataIn(mem_data), .grant(grantMem),
    .full(memFull), .rd(memRd), .data(memData), .load(memLoad)
  );

  // Age flag only matters when both are full; the older entry wins.
  assign grantMem = memFull && (!aluFull || memOlder);
  assign grantAlu = aluFull && !grantMem;
  assign grantSrc = grantMem ? SRC_MEM : SRC_ALU;

  always_comb begin
    memOlderNext = memOlder;
    if (aluLoad && memLoad)
      memOlderNext = 1'b1;
    else if (aluLoad && memFull && !grantMem)
      memOlderNext = 1'b1;
    else if (memLoad && aluFull && !grantAlu)
      memOlderNext = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) memOlder <= 1'b0;
    else      memOlder <= memOlderNext;
  end

  always_comb begin
    rf_we    = grantAlu || grantMem;
    rf_rd    = '0;
    rf_wdata = '0;
    if (rf_we) begin
      case (grantSrc)
        SRC_MEM: begin rf_rd = memRd; rf_wdata = memData; end
        default: begin rf_rd = aluRd; rf_wdata = aluData; end
      endcase
    end
  end

  for (genvar gi = 0; gi < 2 ** ADDR_W; gi++) begin : g_busy
    assign busy_mask[gi] = (aluFull && aluRd == ADDR_W'(gi)) ||
                           (memFull && memRd == ADDR_W'(gi));
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic checked
// against a program-order queue model of pending writes.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          alu_valid = 1'b0, mem_valid = 1'b0;
  logic [AW-1:0] alu_rd = '0, mem_rd = '0;
  logic [DW-1:0] alu_data = '0, mem_data = '0;
  logic          alu_ready, mem_ready, rf_we;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_wdata;
  logic [31:0]   busy_mask;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .busy_mask(busy_mask)
  );

  typedef struct {
    bit            isMem;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } pendEntry_t;

  // Pending writes in program order; the head is the one being written.
  pendEntry_t pend[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit modelReady(input bit isMem);
    foreach (pend[i])
      if (pend[i].isMem == isMem) return (i == 0);
    return 1'b1;
  endfunction

  // Called at a negedge: compare outputs to the model, drive one cycle of
  // inputs, advance the model at the posedge, return at the next negedge.
  task automatic step(input bit aV, input logic [AW-1:0] aRd, input logic [DW-1:0] aD,
                      input bit mV, input logic [AW-1:0] mRd, input logic [DW-1:0] mD);
    logic [31:0] expBusy;
    bit aRdy, mRdy, aHs, mHs;
    expBusy = '0;
    foreach (pend[i]) expBusy[pend[i].rd] = 1'b1;
    aRdy = modelReady(1'b0);
    mRdy = modelReady(1'b1);
    check("rf_we", rf_we, pend.size() > 0);
    check("rf_rd", rf_rd, pend.size() > 0 ? pend[0].rd : '0);
    check("rf_wdata", rf_wdata, pend.size() > 0 ? pend[0].data : '0);
    check("busy_mask", busy_mask, expBusy);
    check("alu_ready", alu_ready, aRdy);
    check("mem_ready", mem_ready, mRdy);
    if (rf_we) $display("write rd=%0d data=%h", rf_rd, rf_wdata);
    alu_valid = aV; alu_rd = aRd; alu_data = aD;
    mem_valid = mV; mem_rd = mRd; mem_data = mD;
    aHs = aV && aRdy;
    mHs = mV && mRdy;
    @(posedge clk);
    if (pend.size() > 0) void'(pend.pop_front());
    if (mHs && mRd != 0) pend.push_back('{1'b1, mRd, mD});
    if (aHs && aRd != 0) pend.push_back('{1'b0, aRd, aD});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0);
  endtask

  // Assert reset mid low phase, check it acts immediately, release at negedge.
  task automatic doReset();
    #2 rst = 1'b0;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    pend.delete();
    #1;
    check("rst_we", rf_we, 1'b0);
    check("rst_busy", busy_mask, 32'h0);
    check("rst_aready", alu_ready, 1'b1);
    check("rst_mready", mem_ready, 1'b1);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
  endtask

  initial begin
    // 1: reset and idle
    #3;
    check("init_we", rf_we, 1'b0);
    check("init_busy", busy_mask, 32'h0);
    check("init_aready", alu_ready, 1'b1);
    check("init_mready", mem_ready, 1'b1);
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    idle(2);

    // 2: single ALU write
    step(1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
    check("t2_we", rf_we, 1'b1);
    check("t2_rd", rf_rd, 5'd5);
    check("t2_data", rf_wdata, 32'hDEADBEEF);
    check("t2_busy", busy_mask, 32'h20);
    idle(1);
    check("t2_we_after", rf_we, 1'b0);
    check("t2_busy_after", busy_mask, 32'h0);

    // 3: simultaneous accept, load wins the tie
    step(1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
    check("t3_rd0", rf_rd, 5'd4);
    check("t3_data0", rf_wdata, 32'h22);
    check("t3_aready", alu_ready, 1'b0);
    check("t3_busy0", busy_mask, 32'h18);
    idle(1);
    check("t3_rd1", rf_rd, 5'd3);
    check("t3_data1", rf_wdata, 32'h11);
    check("t3_busy1", busy_mask, 32'h08);
    idle(1);
    check("t3_busy2", busy_mask, 32'h0);

    // 4: x0 write is swallowed
    step(1, 5'd0, 32'hFFFFFFFF, 0, '0, '0);
    check("t4_we", rf_we, 1'b0);
    check("t4_busy", busy_mask, 32'h0);
    check("t4_aready", alu_ready, 1'b1);

    // 5: older ALU entry is not starved by a load stream
    step(1, 5'd9, 32'h99, 1, 5'd2, 32'h02);
    check("t5_rd0", rf_rd, 5'd2);
    check("t5_mready0", mem_ready, 1'b1);
    step(0, '0, '0, 1, 5'd6, 32'h06);
    check("t5_rd1", rf_rd, 5'd9);
    check("t5_mready1", mem_ready, 1'b0);
    step(0, '0, '0, 1, 5'd7, 32'h07);
    check("t5_rd2", rf_rd, 5'd6);
    check("t5_mready2", mem_ready, 1'b1);
    step(0, '0, '0, 1, 5'd7, 32'h07);
    check("t5_rd3", rf_rd, 5'd7);
    check("t5_mready3", mem_ready, 1'b1);
    idle(1);

    // 6: same rd in both buffers, written in age order
    step(1, 5'd8, 32'hB, 1, 5'd8, 32'hA);
    check("t6_data0", rf_wdata, 32'hA);
    check("t6_busy0", busy_mask, 32'h100);
    idle(1);
    check("t6_data1", rf_wdata, 32'hB);
    check("t6_busy1", busy_mask, 32'h100);
    idle(1);
    check("t6_busy2", busy_mask, 32'h0);

    // 7: reset between accept and grant drops the writes
    step(1, 5'd10, 32'hAA, 1, 5'd11, 32'hBB);
    check("t7_busy_pre", busy_mask, 32'h0C00);
    doReset();
    idle(3);

    // Random traffic with colliding and x0 destinations
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between the two writeback sources of the pipeline: the ALU result path and the load (memory) path.
- Each source has a valid/ready handshake and a one-entry holding buffer.
- The arbiter grants one buffered write per cycle in program order and drives the register file's writeEnable, rd and writeData inputs.
- It exports a busy mask so the hazard unit can stall readers of registers whose writes are still pending.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width; the register count is 2**ADDR_W.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- alu_valid  input  1  ALU writeback request.
- alu_ready  output  1  ALU request accepted this cycle when alu_valid && alu_ready.
- alu_rd  input  ADDR_W  ALU destination register.
- alu_data  input  DATA_W  ALU result.
- mem_valid  input  1  load writeback request.
- mem_ready  output  1  load request accepted when mem_valid && mem_ready.
- mem_rd  input  ADDR_W  load destination register.
- mem_data  input  DATA_W  load data.
- rf_we  output  1  register-file write enable.
- rf_rd  output  ADDR_W  register-file write address.
- rf_wdata  output  DATA_W  register-file write data.
- busy_mask  output  2**ADDR_W  bit r = 1 while a buffered write to register r is pending.

Behaviour:
- State per source: full bit, rd and data registers. Global state: one age flag, mem_older, meaningful only when both buffers are full.
- Reset (rst=0, asynchronous):
  - both full bits = 0, mem_older = 0;
  - outputs therefore: rf_we=0, busy_mask=0, alu_ready=1, mem_ready=1;
  - rf_rd and rf_wdata are driven 0 when rf_we=0.
- Buffer contents at reset:
  - any buffered write is discarded, never written;
  - a reset mid-operation (asserted between accept and grant) drops the pending write.
- Grant, combinational from registered state only:
  - only alu full → grant ALU;
  - only mem full → grant MEM;
  - both full → grant MEM if mem_older=1, else ALU if it filled strictly earlier;
  - both filled on the same edge → tie goes to MEM (the load is older in program order).
- Outputs:
  - rf_we = any grant;
  - rf_rd / rf_wdata = granted buffer's rd / data.
  - Write latency: accepted at edge N; rf_we asserted in cycle N..N+1 when granted; the register file captures at edge N+1.
- Ready:
  - x_ready = !x_full || grant_x.
  - There is no combinational path from any *_valid input to any *_ready output.
  - Each source can stream one write per cycle while it keeps winning the grant.
- Accept on handshake:
  - accepted with rd != 0 → buffer loads rd/data and full=1;
  - granted and not refilled → full=0;
  - granted and refilled on the same edge → full stays 1 with the new contents.
- x0 filtering:
  - a handshake with rd == 0 completes (ready behaves normally) but the buffer is not loaded;
  - x0 never produces rf_we and never sets busy_mask[0].
- Age flag update on each edge:
  - if exactly one buffer becomes newly full while the other stays full and ungranted, the stayed-full one is older;
  - mem_older is set or cleared accordingly;
  - a simultaneous fill of both buffers sets mem_older=1.
- Starvation: a stream of MEM requests cannot block an older ALU entry. The ALU is written no later than the second edge after its acceptance.
- busy_mask:
  - bit r = (alu_full && alu_rd==r) || (mem_full && mem_rd==r);
  - decoded from registered state only.
- Same rd in both buffers: written in age order, so the younger value ends in the register.

Decomposition:
- Shared package:
  - ADDR_W and DATA_W defaults;
  - NUM_REGS = 2**ADDR_W;
  - source encodings SRC_ALU=0, SRC_MEM=1;
  - zero-register constant REG_ZERO=0.
- Sub-module wb_hold_buf:
  - one-entry buffer holding full/rd/data with x0 filtering and ready generation;
  - instantiated twice.
- The top level holds the grant logic, the age flag, the output mux and the busy_mask decode.

Test Plan:
1. Reset, then idle:
   - rf_we=0, busy_mask=0, alu_ready=mem_ready=1;
   - rst asserted asynchronously mid-cycle clears immediately.
2. Single ALU write, alu_rd=5, alu_data=0xDEADBEEF, accepted at edge N:
   - cycle N..N+1: rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF, busy_mask[5]=1;
   - after N+1: busy_mask=0, rf_we=0.
3. Simultaneous alu(rd=3, 0x11) and mem(rd=4, 0x22) at edge N:
   - cycle N+1: write rd=4/0x22, alu_ready=0;
   - cycle N+2: write rd=3/0x11;
   - busy_mask = bits 3|4, then bit 3, then 0.
4. alu_rd=0 with data 0xFFFFFFFF:
   - handshake completes;
   - rf_we stays 0, busy_mask stays 0, alu_ready stays 1.
5. ALU rd=9 accepted at edge N together with mem rd=2; mem then streams rd=2,6,7 on every subsequent edge:
   - writes occur in order 2, 9, 6, 7 on consecutive cycles;
   - mem_ready=0 for exactly one cycle (while the ALU is granted).
6. Both sources write rd=8 on the same edge (mem 0xA, alu 0xB):
   - writes 0xA then 0xB;
   - busy_mask[8] stays 1 for two cycles.
7. Requests accepted at edge N, then rst=0 before edge N+1:
   - no rf_we ever asserted for them;
   - after release, busy_mask=0 and both readies are 1.
